mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 141 ++++++++++++++
 tb/tb_mem_stage.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage of a 32-bit MIPS-style core.
//   Holds the data memory (MEM_DEPTH 32-bit words, byte-lane writes, not cleared
//   by reset). Reads are asynchronous. The read word is lane-aligned and then
//   registered into the MEM/WB register together with the pass-through fields.
//
// Ports:
//   i_clk, i_reset (sync, active-high), i_step (advance enable)
//   i_exmem_*  : EX/MEM register fields (address/ALU result, store data, controls)
//   o_memwb_*  : MEM/WB register fields (load data plus registered pass-throughs)
//   i_debug_addr / o_debug_data : combinational word read port, present only
//                                 when the macro MEM_DEBUG_PORT_EN is defined.
module mem_stage #(
  parameter int BITS_SIZE = 32,
  parameter int BITS_REGS = 5,
  parameter int MEM_DEPTH = 256
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_step,
  input  logic [BITS_SIZE-1:0] i_exmem_alu,
  input  logic [BITS_SIZE-1:0] i_exmem_data_write,
  input  logic                 i_exmem_mem_write,
  input  logic [1:0]           i_exmem_size_filterS,
  input  logic                 i_exmem_reg_write,
  input  logic                 i_exmem_halt,
  input  logic                 i_exmem_lui,
  input  logic [BITS_SIZE-1:0] i_exmem_extension,
  input  logic [1:0]           i_exmem_size_filterL,
  input  logic                 i_exmem_zero_extend,
  input  logic                 i_exmem_mem_to_reg,
  input  logic                 i_exmem_jal,
  input  logic [BITS_SIZE-1:0] i_exmem_pc8,
  input  logic [BITS_REGS-1:0] i_exmem_register_dst,
  output logic [BITS_SIZE-1:0] o_memwb_dato_mem,
  output logic                 o_memwb_reg_write,
  output logic                 o_memwb_halt,
  output logic                 o_memwb_lui,
  output logic [BITS_SIZE-1:0] o_memwb_extension,
  output logic [1:0]           o_memwb_size_filterL,
  output logic                 o_memwb_zero_extend,
  output logic                 o_memwb_mem_to_reg,
  output logic                 o_memwb_jal,
  output logic [BITS_SIZE-1:0] o_memwb_pc8,
  output logic [BITS_REGS-1:0] o_memwb_register_dst,
  output logic [BITS_SIZE-1:0] o_memwb_alu
`ifdef MEM_DEBUG_PORT_EN
  ,
  input  logic [$clog2(MEM_DEPTH)-1:0] i_debug_addr,
  output logic [BITS_SIZE-1:0]         o_debug_data
`endif
);

  localparam int AW = $clog2(MEM_DEPTH);

  logic [BITS_SIZE-1:0] mem_q [MEM_DEPTH];

  logic [AW-1:0]        widx;
  logic [3:0]           be;
  logic [BITS_SIZE-1:0] wdata;
  logic [BITS_SIZE-1:0] rd_word;
  logic [BITS_SIZE-1:0] dato_d;

  // Upper address bits are dropped, so addresses wrap modulo MEM_DEPTH words.
  assign widx    = i_exmem_alu[AW+1:2];
  assign rd_word = mem_q[widx];

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    be    = 4'hF;
    wdata = i_exmem_data_write;
    case (i_exmem_size_filterS)
      2'b01: begin
        be    = i_exmem_alu[1] ? 4'b1100 : 4'b0011;
        wdata = {2{i_exmem_data_write[15:0]}};
      end
      2'b10: begin
        be    = 4'b0001 << i_exmem_alu[1:0];
        wdata = {4{i_exmem_data_write[7:0]}};
      end
      default: begin
        be    = 4'hF;
        wdata = i_exmem_data_write;
      end
    endcase
  end

  // Memory is deliberately outside reset; reset only blocks the write.
  always_ff @(posedge i_clk) begin
    if (!i_reset && i_step && i_exmem_mem_write) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[widx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Right-align the addressed lane; sign/zero extension happens in WB.
  always_comb begin
    dato_d = rd_word;
    case (i_exmem_size_filterL)
      2'b10:   dato_d = rd_word >> {i_exmem_alu[1:0], 3'b000};
      2'b01:   dato_d = rd_word >> {i_exmem_alu[1], 4'b0000};
      default: dato_d = rd_word;
    endcase
  end

  // MEM/WB register boundary
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_memwb_dato_mem     <= '0;
      o_memwb_reg_write    <= 1'b0;
      o_memwb_halt         <= 1'b0;
      o_memwb_lui          <= 1'b0;
      o_memwb_extension    <= '0;
      o_memwb_size_filterL <= '0;
      o_memwb_zero_extend  <= 1'b0;
      o_memwb_mem_to_reg   <= 1'b0;
      o_memwb_jal          <= 1'b0;
      o_memwb_pc8          <= '0;
      o_memwb_register_dst <= '0;
      o_memwb_alu          <= '0;
    end else if (i_step) begin
      o_memwb_dato_mem     <= dato_d;
      o_memwb_reg_write    <= i_exmem_reg_write;
      o_memwb_halt         <= i_exmem_halt;
      o_memwb_lui          <= i_exmem_lui;
      o_memwb_extension    <= i_exmem_extension;
      o_memwb_size_filterL <= i_exmem_size_filterL;
      o_memwb_zero_extend  <= i_exmem_zero_extend;
      o_memwb_mem_to_reg   <= i_exmem_mem_to_reg;
      o_memwb_jal          <= i_exmem_jal;
      o_memwb_pc8          <= i_exmem_pc8;
      o_memwb_register_dst <= i_exmem_register_dst;
      o_memwb_alu          <= i_exmem_alu;
    end
  end

`ifdef MEM_DEBUG_PORT_EN
  assign o_debug_data = mem_q[i_debug_addr];
`endif

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic        i_clk = 1'b0;
  logic        i_reset, i_step;
  logic [31:0] i_exmem_alu, i_exmem_data_write, i_exmem_extension, i_exmem_pc8;
  logic        i_exmem_mem_write, i_exmem_reg_write, i_exmem_halt, i_exmem_lui;
  logic [1:0]  i_exmem_size_filterS, i_exmem_size_filterL;
  logic        i_exmem_zero_extend, i_exmem_mem_to_reg, i_exmem_jal;
  logic [4:0]  i_exmem_register_dst;
  logic [31:0] o_memwb_dato_mem, o_memwb_extension, o_memwb_pc8, o_memwb_alu;
  logic        o_memwb_reg_write, o_memwb_halt, o_memwb_lui;
  logic [1:0]  o_memwb_size_filterL;
  logic        o_memwb_zero_extend, o_memwb_mem_to_reg, o_memwb_jal;
  logic [4:0]  o_memwb_register_dst;
`ifdef MEM_DEBUG_PORT_EN
  logic [7:0]  i_debug_addr;
  logic [31:0] o_debug_data;
`endif

  always #5 i_clk = ~i_clk;

  mem_stage dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_step(i_step),
    .i_exmem_alu(i_exmem_alu), .i_exmem_data_write(i_exmem_data_write),
    .i_exmem_mem_write(i_exmem_mem_write), .i_exmem_size_filterS(i_exmem_size_filterS),
    .i_exmem_reg_write(i_exmem_reg_write), .i_exmem_halt(i_exmem_halt),
    .i_exmem_lui(i_exmem_lui), .i_exmem_extension(i_exmem_extension),
    .i_exmem_size_filterL(i_exmem_size_filterL), .i_exmem_zero_extend(i_exmem_zero_extend),
    .i_exmem_mem_to_reg(i_exmem_mem_to_reg), .i_exmem_jal(i_exmem_jal),
    .i_exmem_pc8(i_exmem_pc8), .i_exmem_register_dst(i_exmem_register_dst),
    .o_memwb_dato_mem(o_memwb_dato_mem), .o_memwb_reg_write(o_memwb_reg_write),
    .o_memwb_halt(o_memwb_halt), .o_memwb_lui(o_memwb_lui),
    .o_memwb_extension(o_memwb_extension), .o_memwb_size_filterL(o_memwb_size_filterL),
    .o_memwb_zero_extend(o_memwb_zero_extend), .o_memwb_mem_to_reg(o_memwb_mem_to_reg),
    .o_memwb_jal(o_memwb_jal), .o_memwb_pc8(o_memwb_pc8),
    .o_memwb_register_dst(o_memwb_register_dst), .o_memwb_alu(o_memwb_alu)
`ifdef MEM_DEBUG_PORT_EN
    , .i_debug_addr(i_debug_addr), .o_debug_data(o_debug_data)
`endif
  );

  typedef struct packed {
    logic [31:0] dato, alu, ext, pc8;
    logic [4:0]  rdst;
    logic [1:0]  szl;
    logic        lui, zext, m2r, jal, rw, halt;
  } out_t;

  out_t        sb_q[$];
  out_t        last;
  logic [7:0]  mb [1024];
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] szl);
    int base;
    logic [31:0] w;
    base = int'(a[9:2]) * 4;
    w = {mb[base+3], mb[base+2], mb[base+1], mb[base]};
    if (szl == 2'b10)      w = w >> (8 * int'(a[1:0]));
    else if (szl == 2'b01) w = w >> (16 * int'(a[1]));
    return w;
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] szs);
    int base;
    base = int'(a[9:2]) * 4;
    case (szs)
      2'b01: begin
        base = base + (a[1] ? 2 : 0);
        mb[base] = d[7:0];
        mb[base+1] = d[15:8];
      end
      2'b10: mb[base + int'(a[1:0])] = d[7:0];
      default: begin
        mb[base] = d[7:0];   mb[base+1] = d[15:8];
        mb[base+2] = d[23:16]; mb[base+3] = d[31:24];
      end
    endcase
  endtask

  // One instruction slot: drive, push expectation, clock, pop and compare all fields.
  task automatic op(input string nm, input logic rst, input logic step, input logic we,
                    input logic [1:0] szs, input logic [1:0] szl,
                    input logic [31:0] a, input logic [31:0] d);
    out_t e;
    i_reset = rst; i_step = step; i_exmem_mem_write = we;
    i_exmem_size_filterS = szs; i_exmem_size_filterL = szl;
    i_exmem_alu = a; i_exmem_data_write = d;
    if (rst) begin
      i_exmem_reg_write = 1'b1; i_exmem_halt = 1'b1; i_exmem_lui = 1'b1;
      i_exmem_extension = '1; i_exmem_zero_extend = 1'b1; i_exmem_mem_to_reg = 1'b1;
      i_exmem_jal = 1'b1; i_exmem_pc8 = '1; i_exmem_register_dst = '1;
    end else begin
      i_exmem_reg_write = 1'($urandom); i_exmem_halt = 1'($urandom); i_exmem_lui = 1'($urandom);
      i_exmem_extension = $urandom; i_exmem_zero_extend = 1'($urandom);
      i_exmem_mem_to_reg = 1'($urandom); i_exmem_jal = 1'($urandom);
      i_exmem_pc8 = $urandom; i_exmem_register_dst = 5'($urandom);
    end
    e.dato = model_load(a, szl);
    e.alu = a; e.ext = i_exmem_extension; e.pc8 = i_exmem_pc8;
    e.rdst = i_exmem_register_dst; e.szl = szl; e.lui = i_exmem_lui;
    e.zext = i_exmem_zero_extend; e.m2r = i_exmem_mem_to_reg; e.jal = i_exmem_jal;
    e.rw = i_exmem_reg_write; e.halt = i_exmem_halt;
    if (step && !rst) begin
      sb_q.push_back(e);
      if (we) model_store(a, d, szs);
    end
    @(posedge i_clk);
    #1;
    if (rst) begin
      last = '0;
    end else if (step) begin
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL %s.scoreboard: got empty queue expected an entry", nm);
      end else begin
        last = sb_q.pop_front();
      end
    end
    chk({nm, ".dato"}, o_memwb_dato_mem, last.dato);
    chk({nm, ".alu"},  o_memwb_alu, last.alu);
    chk({nm, ".ext"},  o_memwb_extension, last.ext);
    chk({nm, ".pc8"},  o_memwb_pc8, last.pc8);
    chk({nm, ".rdst"}, 32'(o_memwb_register_dst), 32'(last.rdst));
    chk({nm, ".szl"},  32'(o_memwb_size_filterL), 32'(last.szl));
    chk({nm, ".ctl"},
        32'({o_memwb_lui, o_memwb_zero_extend, o_memwb_mem_to_reg, o_memwb_jal,
             o_memwb_reg_write, o_memwb_halt}),
        32'({last.lui, last.zext, last.m2r, last.jal, last.rw, last.halt}));
  endtask

  initial begin
    last = '0;
    // reset state
    op("rst0", 1, 0, 0, 2'b00, 2'b00, 32'h0, 32'h0);
    op("rst1", 1, 1, 0, 2'b00, 2'b00, 32'h0, 32'h0);
    // seed memory
    op("sw_20", 0, 1, 1, 2'b00, 2'b00, 32'h20, 32'h0);
    op("sw_0c", 0, 1, 1, 2'b00, 2'b00, 32'h0C, 32'hDEADBEEF);
    op("sw_3fc", 0, 1, 1, 2'b11, 2'b00, 32'h3FC, 32'h12345678);
    op("sw_18", 0, 1, 1, 2'b00, 2'b00, 32'h18, 32'h0BADF00D);
    // reset with all-ones inputs: outputs clear, store to word 255 blocked
    op("rst_ones", 1, 1, 1, 2'b11, 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF);
    op("lw_0c", 0, 1, 0, 2'b00, 2'b00, 32'h0C, 32'h0);
    op("lw_3fc", 0, 1, 0, 2'b00, 2'b00, 32'h3FC, 32'h0);
    chk("persist_0c", model_load(32'h0C, 2'b00), 32'hDEADBEEF);
    // SW / SB / LW merge
    op("sw_10", 0, 1, 1, 2'b00, 2'b00, 32'h10, 32'h11223344);
    op("sb_11", 0, 1, 1, 2'b10, 2'b00, 32'h11, 32'h000000AA);
    op("lw_10", 0, 1, 0, 2'b00, 2'b00, 32'h10, 32'h0);
    chk("merge_10", o_memwb_dato_mem, 32'h1122AA44);
    // byte loads are shifted, not masked
    op("lb_13", 0, 1, 0, 2'b00, 2'b10, 32'h13, 32'h0);
    chk("lb_13v", o_memwb_dato_mem, 32'h00000011);
    op("lb_11", 0, 1, 0, 2'b00, 2'b10, 32'h11, 32'h0);
    chk("lb_11v", o_memwb_dato_mem, 32'h001122AA);
    // halfword store / loads
    op("sh_22", 0, 1, 1, 2'b01, 2'b00, 32'h22, 32'h1234BEEF);
    op("lh_22", 0, 1, 0, 2'b00, 2'b01, 32'h22, 32'h0);
    chk("lh_22v", o_memwb_dato_mem[15:0], 32'hBEEF);
    op("lw_20", 0, 1, 0, 2'b00, 2'b00, 32'h20, 32'h0);
    chk("lw_20v", o_memwb_dato_mem, 32'hBEEF0000);
    op("sh_21", 0, 1, 1, 2'b01, 2'b00, 32'h21, 32'h00005A5A);
    op("lw_20b", 0, 1, 0, 2'b00, 2'b00, 32'h20, 32'h0);
    chk("sh_a0ign", o_memwb_dato_mem, 32'hBEEF5A5A);
    // stall with a pending store: nothing changes
    for (int i = 0; i < 3; i++)
      op("stall", 0, 0, 1, 2'b00, 2'b00, 32'h18, 32'h00000077);
    op("lw_18", 0, 1, 0, 2'b00, 2'b00, 32'h18, 32'h0);
    chk("stall_nowr", o_memwb_dato_mem, 32'h0BADF00D);
    op("sw_14", 0, 1, 1, 2'b00, 2'b00, 32'h14, 32'h00000066);
    op("lw_14", 0, 1, 0, 2'b00, 2'b00, 32'h14, 32'h0);
    // address wrap
    op("sw_400", 0, 1, 1, 2'b00, 2'b00, 32'h400, 32'hCAFEF00D);
    op("lw_0", 0, 1, 0, 2'b00, 2'b00, 32'h0, 32'h0);
    chk("wrap", o_memwb_dato_mem, 32'hCAFEF00D);
    // reset mid-stall, then hold, then first capture
    op("rst_stall", 1, 0, 1, 2'b00, 2'b00, 32'h0, 32'h0);
    op("hold0", 0, 0, 0, 2'b00, 2'b00, 32'h0C, 32'h0);
    op("cap", 0, 1, 0, 2'b00, 2'b00, 32'h0C, 32'h0);
    chk("cap_v", o_memwb_dato_mem, 32'hDEADBEEF);
    op("lw_3fc2", 0, 1, 0, 2'b00, 2'b00, 32'h3FC, 32'h0);
    chk("rst_nowr", o_memwb_dato_mem, 32'h12345678);
`ifdef MEM_DEBUG_PORT_EN
    op("sw_10d", 0, 1, 1, 2'b00, 2'b00, 32'h10, 32'h00000005);
    i_debug_addr = 8'd4;
    #1;
    chk("debug", o_debug_data, 32'h00000005);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
